// File: rtl/button_debouncer_if.sv
// Button bundle between the raw pins and the debouncer: raw pin levels in,
// debounced level and per-channel busy flags out.
interface button_debouncer_if #(
  parameter int unsigned NUM_BTN = 4
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_busy;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_busy
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_busy
  );
endinterface

// File: rtl/button_debouncer.sv
// Per-channel push-button conditioning: 2-FF synchroniser, polarity normalisation and a
// 4-state debounce FSM that needs DEBOUNCE_CYCLES consecutive samples to accept a change.
module button_debouncer #(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  button_debouncer_if.slave   btn
);

  typedef enum logic [1:0] {
    StReleased,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  localparam logic [NUM_BTN-1:0] RelVal  = ACTIVE_LOW ? {NUM_BTN{1'b1}} : {NUM_BTN{1'b0}};
  localparam logic [CNT_W-1:0]   CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CntOne  = CNT_W'(1);

  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;
  logic [NUM_BTN-1:0] pressed;
  logic [NUM_BTN-1:0] level_vec;
  logic [NUM_BTN-1:0] busy_vec;

  // Reset loads the released pin value so no phantom press follows reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= RelVal;
      sync2_q <= RelVal;
    end else begin
      sync1_q <= btn.btn_raw;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = ACTIVE_LOW ? ~sync2_q : sync2_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : gen_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             busy_q, busy_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
        StReleased: begin
          if (pressed[i]) begin
            state_d = StPressWait;
            cnt_d   = CntOne;
          end
        end
        StPressWait: begin
          if (!pressed[i]) begin
            state_d = StReleased;
          end else if (cnt_q == CntLast) begin
            state_d = StPressed;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StPressed: begin
          if (!pressed[i]) begin
            state_d = StReleaseWait;
            cnt_d   = CntOne;
          end
        end
        StReleaseWait: begin
          if (pressed[i]) begin
            state_d = StPressed;
          end else if (cnt_q == CntLast) begin
            state_d = StReleased;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: state_d = StReleased;
      endcase
    end

    // Outputs are decoded from the next state so they move on the same edge as the FSM.
    always_comb begin
      level_d = (state_d == StPressed) || (state_d == StReleaseWait);
      busy_d  = (state_d == StPressWait) || (state_d == StReleaseWait);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= StReleased;
        cnt_q   <= '0;
        level_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        busy_q  <= busy_d;
      end
    end

    assign level_vec[i] = level_q;
    assign busy_vec[i]  = busy_q;
  end

  assign btn.btn_level = level_vec;
  assign btn.btn_busy  = busy_vec;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed scenarios plus a randomized soak, checked every cycle against a run-length
// model of the debounce rules.
module tb_button_debouncer;
  localparam int unsigned N = 4;
  localparam int unsigned D = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  button_debouncer_if #(.NUM_BTN(N)) bif ();

  button_debouncer #(
    .NUM_BTN        (N),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (4),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .btn  (bif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: two-sample delay of the pin, then a count of consecutive samples that
  // disagree with the current level; D of them in a row flip the level.
  logic [N-1:0] m_pipe1, m_pipe2, m_level;
  int           m_run [N];
  logic [N-1:0] prev_level;
  int           rises [N];

  always @(posedge clk) begin
    if (reset) begin
      m_pipe1 <= '1;
      m_pipe2 <= '1;
      m_level <= '0;
      for (int i = 0; i < N; i++) m_run[i] <= 0;
    end else begin
      m_pipe1 <= bif.btn_raw;
      m_pipe2 <= m_pipe1;
      for (int i = 0; i < N; i++) begin
        if (!m_pipe2[i] != m_level[i]) begin
          if (m_run[i] + 1 == int'(D)) begin
            m_level[i] <= ~m_level[i];
            m_run[i]   <= 0;
          end else begin
            m_run[i] <= m_run[i] + 1;
          end
        end else begin
          m_run[i] <= 0;
        end
      end
    end
  end

  function automatic logic [N-1:0] m_busy();
    logic [N-1:0] b;
    for (int i = 0; i < N; i++) b[i] = (m_run[i] != 0);
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One cycle: sample at the falling edge and compare the whole output bundle.
  task automatic tick();
    @(negedge clk);
    check("level_vs_model", 32'(bif.btn_level), 32'(m_level));
    check("busy_vs_model", 32'(bif.btn_busy), 32'(m_busy()));
    for (int i = 0; i < N; i++)
      if (bif.btn_level[i] && !prev_level[i]) rises[i]++;
    prev_level = bif.btn_level;
  endtask

  task automatic hold(input int ch, input logic val, input int n);
    bif.btn_raw[ch] = val;
    repeat (n) tick();
  endtask

  // Ticks lat cycles; the level must stay put until exactly the lat-th cycle.
  task automatic expect_change(input int ch, input logic val, input int lat, input string tag,
                               output int busy_cycles);
    busy_cycles = 0;
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (bif.btn_busy[ch]) busy_cycles++;
      if (k < lat) check({tag, "_early"}, 32'(bif.btn_level[ch]), 32'(!val));
      else         check({tag, "_at_lat"}, 32'(bif.btn_level[ch]), 32'(val));
    end
  endtask

  initial begin
    int bc;
    int hold_left [N];
    bif.btn_raw = '1;
    prev_level  = '0;
    for (int i = 0; i < N; i++) rises[i] = 0;
    @(negedge clk);
    @(negedge clk);
    check("reset_level", 32'(bif.btn_level), 32'h0);
    check("reset_busy", 32'(bif.btn_busy), 32'h0);
    reset = 1'b0;
    repeat (3) tick();

    // Clean press: 2 sync + D samples; busy spans the wait from its first to last sample.
    bif.btn_raw[0] = 1'b0;
    expect_change(0, 1'b1, D + 2, "clean_press", bc);
    check("clean_press_busy_cycles", 32'(bc), 32'(D - 1));
    check("clean_press_busy_after", 32'(bif.btn_busy[0]), 32'h0);

    // Bounce on channel 1, then a held press.
    hold(1, 1'b0, 5);
    hold(1, 1'b1, 1);
    hold(1, 1'b0, 3);
    hold(1, 1'b1, 2);
    check("bounce_no_level", 32'(bif.btn_level[1]), 32'h0);
    rises[1] = 0;
    bif.btn_raw[1] = 1'b0;
    expect_change(1, 1'b1, D + 2, "bounce_press", bc);
    repeat (4) tick();
    check("bounce_single_edge", 32'(rises[1]), 32'd1);

    // Short glitch on channel 2 (D-1 samples) is rejected.
    hold(2, 1'b0, D - 1);
    hold(2, 1'b1, D + 6);
    check("glitch_level", 32'(bif.btn_level[2]), 32'h0);
    check("glitch_busy", 32'(bif.btn_busy[2]), 32'h0);

    // Release glitch on channel 0 is rejected, then a real release.
    hold(0, 1'b1, D - 1);
    hold(0, 1'b0, D + 6);
    check("rel_glitch_level", 32'(bif.btn_level[0]), 32'h1);
    bif.btn_raw[0] = 1'b1;
    expect_change(0, 1'b0, D + 2, "release", bc);

    // Reset in the middle of a press wait on channel 3.
    hold(3, 1'b0, 5);
    reset = 1'b1;
    repeat (3) begin
      tick();
      check("midreset_level", 32'(bif.btn_level), 32'h0);
      check("midreset_busy", 32'(bif.btn_busy), 32'h0);
    end
    reset = 1'b0;
    expect_change(3, 1'b1, D + 2, "after_reset", bc);

    // Parallel presses with different bounce patterns.
    bif.btn_raw = '1;
    repeat (D + 6) tick();
    check("par_idle", 32'(bif.btn_level), 32'h0);
    bif.btn_raw[0] = 1'b0;
    bif.btn_raw[3] = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("par_ch0", 32'(bif.btn_level[0]), 32'(k >= int'(D) + 2));
      check("par_ch3", 32'(bif.btn_level[3]), 32'(k >= int'(D) + 5));
      if (k == 2) bif.btn_raw[3] = 1'b1;
      if (k == 3) bif.btn_raw[3] = 1'b0;
    end

    // Randomized soak: hold lengths straddle D so both accepts and rejects occur.
    for (int i = 0; i < N; i++) hold_left[i] = 0;
    for (int c = 0; c < 1200; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold_left[i] == 0) begin
          bif.btn_raw[i] = 1'($urandom_range(0, 1));
          hold_left[i]   = int'($urandom_range(1, 2 * D + 2));
        end
        hold_left[i]--;
      end
      reset = (c >= 600 && c < 603) || ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
